// File: rtl/inverse_clark_transform_if.sv
// Stream bundle for the inverse Clarke block: alpha/beta/gamma in, phase a/b/c out.
// master = surrounding datapath, slave = the transform itself.
interface inverse_clark_transform_if #(
  parameter int W = 16
);
  logic                inValid;
  logic                inReady;
  logic signed [W-1:0] alpha;
  logic signed [W-1:0] beta;
  logic signed [W-1:0] gamma;
  logic                outValid;
  logic                outReady;
  logic signed [W-1:0] a;
  logic signed [W-1:0] b;
  logic signed [W-1:0] c;

  modport master (
    output inValid, alpha, beta, gamma, outReady,
    input  inReady, outValid, a, b, c
  );

  modport slave (
    input  inValid, alpha, beta, gamma, outReady,
    output inReady, outValid, a, b, c
  );
endinterface

// File: rtl/inverse_clark_transform.sv
// Inverse Clarke transform (amplitude-invariant) for the SVPWM datapath.
// Three pipeline stages sharing one advance enable; saturated signed outputs and a sticky clip flag.
module inverse_clark_transform #(
  parameter int W         = 16,
  parameter int FRAC      = 15,
  parameter int K_SQRT3_2 = 28378
) (
  input  logic                        clk,
  input  logic                        rst_n,
  inverse_clark_transform_if.slave    bus,
  input  logic                        clrSat_i,
  output logic                        satFlag_o
);

  localparam int SW = W + 2;
  localparam logic signed [2*W-1:0] KCoef     = (2*W)'(K_SQRT3_2);
  localparam logic signed [2*W-1:0] RoundBias = (2*W)'(2 ** (FRAC - 1));
  localparam logic signed [W-1:0]   MaxOut    = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0]   MinOut    = {1'b1, {(W-1){1'b0}}};

  logic advance;

  logic                  s1Valid_q, s1Valid_d;
  logic signed [W-1:0]   s1Alpha_q, s1Alpha_d;
  logic signed [W-1:0]   s1Gamma_q, s1Gamma_d;
  logic signed [2*W-1:0] s1Prod_q,  s1Prod_d;

  logic                  s2Valid_q, s2Valid_d;
  logic signed [SW-1:0]  s2SumA_q,  s2SumA_d;
  logic signed [SW-1:0]  s2SumB_q,  s2SumB_d;
  logic signed [SW-1:0]  s2SumC_q,  s2SumC_d;

  logic                  outValid_q, outValid_d;
  logic signed [W-1:0]   a_q, a_d;
  logic signed [W-1:0]   b_q, b_d;
  logic signed [W-1:0]   c_q, c_d;
  logic                  satFlag_q, satFlag_d;
  logic                  anyClip;

  logic signed [SW-1:0]  pRound;
  logic signed [SW-1:0]  negHalf;
  logic signed [SW-1:0]  alphaX;
  logic signed [SW-1:0]  gammaX;

  // A value fits in W bits only if its top three bits are all equal.
  function automatic logic clips(input logic signed [SW-1:0] x);
    return !((&x[SW-1:W-1]) || !(|x[SW-1:W-1]));
  endfunction

  function automatic logic signed [W-1:0] saturate(input logic signed [SW-1:0] x);
    if (clips(x)) begin
      return x[SW-1] ? MinOut : MaxOut;
    end
    return x[W-1:0];
  endfunction

  // The whole pipe moves only when the output register is free or being drained.
  assign advance     = !outValid_q || bus.outReady;
  assign bus.inReady = advance;

  always_comb begin
    s1Valid_d = bus.inValid;
    s1Alpha_d = bus.alpha;
    s1Gamma_d = bus.gamma;
    s1Prod_d  = (2*W)'(bus.beta) * KCoef;
  end

  // P is rounded once here and shared by b and c, keeping them antisymmetric in beta.
  always_comb begin
    pRound    = SW'((s1Prod_q + RoundBias) >>> FRAC);
    negHalf   = -SW'(s1Alpha_q >>> 1);
    alphaX    = SW'(s1Alpha_q);
    gammaX    = SW'(s1Gamma_q);
    s2Valid_d = s1Valid_q;
    s2SumA_d  = alphaX + gammaX;
    s2SumB_d  = negHalf + pRound + gammaX;
    s2SumC_d  = negHalf - pRound + gammaX;
  end

  always_comb begin
    outValid_d = s2Valid_q;
    a_d        = saturate(s2SumA_q);
    b_d        = saturate(s2SumB_q);
    c_d        = saturate(s2SumC_q);
    anyClip    = s2Valid_q && (clips(s2SumA_q) || clips(s2SumB_q) || clips(s2SumC_q));
    satFlag_d  = satFlag_q;
    if (clrSat_i) begin
      satFlag_d = 1'b0;
    end
    if (advance && anyClip) begin
      satFlag_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid_q  <= 1'b0;
      s1Alpha_q  <= '0;
      s1Gamma_q  <= '0;
      s1Prod_q   <= '0;
      s2Valid_q  <= 1'b0;
      s2SumA_q   <= '0;
      s2SumB_q   <= '0;
      s2SumC_q   <= '0;
      outValid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      satFlag_q  <= 1'b0;
    end else begin
      if (advance) begin
        s1Valid_q  <= s1Valid_d;
        s1Alpha_q  <= s1Alpha_d;
        s1Gamma_q  <= s1Gamma_d;
        s1Prod_q   <= s1Prod_d;
        s2Valid_q  <= s2Valid_d;
        s2SumA_q   <= s2SumA_d;
        s2SumB_q   <= s2SumB_d;
        s2SumC_q   <= s2SumC_d;
        outValid_q <= outValid_d;
        a_q        <= a_d;
        b_q        <= b_d;
        c_q        <= c_d;
      end
      satFlag_q <= satFlag_d;
    end
  end

  assign bus.outValid = outValid_q;
  assign bus.a        = a_q;
  assign bus.b        = b_q;
  assign bus.c        = c_q;
  assign satFlag_o    = satFlag_q;

endmodule

// File: tb/tb_inverse_clark_transform.sv
// Scoreboard bench for inverse_clark_transform: directed corner cases, backpressure,
// mid-stream reset and randomized traffic against an integer reference model.
module tb_inverse_clark_transform;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clrSat = 1'b0;
  logic satFlag;

  inverse_clark_transform_if #(.W(W)) bus ();

  inverse_clark_transform #(.W(W), .FRAC(15), .K_SQRT3_2(28378)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .clrSat_i (clrSat),
    .satFlag_o(satFlag)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int c;
    bit clip;
  } expT;

  expT scoreboard[$];
  int  vectorsApplied = 0;
  int  miscompares = 0;
  int  checks = 0;
  bit  randReady = 1'b0;
  bit  clrActive = 1'b0;
  bit  sawClip = 1'b0;

  // Reference: plain integer maths with floor shifts and a clamp to the W-bit range.
  function automatic int clamp(input int v, output bit clipped);
    clipped = 1'b0;
    if (v > 32767) begin
      clipped = 1'b1;
      return 32767;
    end
    if (v < -32768) begin
      clipped = 1'b1;
      return -32768;
    end
    return v;
  endfunction

  function automatic expT refModel(input int al, input int be, input int ga);
    expT e;
    int p;
    int half;
    bit c0, c1, c2;
    p      = (be * 28378 + 16384) >>> 15;
    half   = al >>> 1;
    e.a    = clamp(al + ga, c0);
    e.b    = clamp(-half + p + ga, c1);
    e.c    = clamp(-half - p + ga, c2);
    e.clip = c0 | c1 | c2;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic signed [31:0] actual,
                             input logic signed [31:0] expected);
    checks++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic signed [W-1:0] al, input logic signed [W-1:0] be,
                               input logic signed [W-1:0] ga);
    int waitCycles = 0;
    bit accepted = 1'b0;
    @(negedge clk);
    bus.inValid = 1'b1;
    bus.alpha   = al;
    bus.beta    = be;
    bus.gamma   = ga;
    while (!accepted && waitCycles < 200) begin
      #1;
      if (bus.inReady) begin
        scoreboard.push_back(refModel(al, be, ga));
        vectorsApplied++;
        accepted = 1'b1;
      end else begin
        @(negedge clk);
        waitCycles++;
      end
    end
    if (!accepted) begin
      checks++;
      miscompares++;
      $display("[TB] FAIL acceptTimeout: got in_ready=0 for %0d cycles, expected 1", waitCycles);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.inValid = 1'b0;
    end
  endtask

  task automatic waitDrain();
    int n = 0;
    do begin
      @(negedge clk);
      #3;
      n++;
    end while ((scoreboard.size() != 0 || bus.outValid) && n < 500);
    if (n >= 500) begin
      checks++;
      miscompares++;
      $display("[TB] FAIL drainTimeout: got %0d pending, expected 0", scoreboard.size());
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (randReady) bus.outReady = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops on every transfer, and checks held outputs stay put under backpressure.
  initial begin
    expT e;
    bit  holdValid = 1'b0;
    logic signed [W-1:0] heldA, heldB, heldC;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        holdValid = 1'b0;
      end else begin
        if (holdValid) begin
          checkOutput("holdValid", bus.outValid, 1);
          checkOutput("holdA", bus.a, heldA);
          checkOutput("holdB", bus.b, heldB);
          checkOutput("holdC", bus.c, heldC);
        end
        holdValid = 1'b0;
        if (bus.outValid && bus.outReady) begin
          if (scoreboard.size() == 0) begin
            checks++;
            miscompares++;
            $display("[TB] FAIL unexpectedOutput: got a=%0d b=%0d c=%0d, expected no output",
                     bus.a, bus.b, bus.c);
          end else begin
            e = scoreboard.pop_front();
            checkOutput("outA", bus.a, e.a);
            checkOutput("outB", bus.b, e.b);
            checkOutput("outC", bus.c, e.c);
            if (e.clip) sawClip = 1'b1;
            if (e.clip || !clrActive) checkOutput("satFlag", satFlag, sawClip);
          end
        end else if (bus.outValid) begin
          holdValid = 1'b1;
          heldA = bus.a;
          heldB = bus.b;
          heldC = bus.c;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic signed [W-1:0] ra, rb, rg;
    bus.inValid  = 1'b0;
    bus.alpha    = '0;
    bus.beta     = '0;
    bus.gamma    = '0;
    bus.outReady = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("resetOutValid", bus.outValid, 0);
    checkOutput("resetA", bus.a, 0);
    checkOutput("resetB", bus.b, 0);
    checkOutput("resetC", bus.c, 0);
    checkOutput("resetSatFlag", satFlag, 0);
    checkOutput("resetInReady", bus.inReady, 1);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed vectors");
    applyStimulus(16384, 0, 0);
    applyStimulus(0, 1000, 0);
    applyStimulus(0, -1000, 0);
    applyStimulus(-3, 0, 0);
    idle(1);
    waitDrain();
    checkOutput("satFlagClean", satFlag, 0);

    applyStimulus(32767, 0, 32767);
    idle(1);
    waitDrain();
    checkOutput("satFlagSet", satFlag, 1);
    @(negedge clk);
    clrSat = 1'b1;
    @(negedge clk);
    clrSat = 1'b0;
    sawClip = 1'b0;
    #3;
    checkOutput("satFlagCleared", satFlag, 0);

    $display("[TB] clear held during a clipping load");
    @(negedge clk);
    clrSat = 1'b1;
    clrActive = 1'b1;
    applyStimulus(-32768, 0, -32768);
    idle(1);
    waitDrain();
    checkOutput("satFlagClrAfter", satFlag, 0);
    @(negedge clk);
    clrSat = 1'b0;
    clrActive = 1'b0;
    sawClip = 1'b0;

    $display("[TB] backpressure");
    @(negedge clk);
    bus.outReady = 1'b0;
    applyStimulus(100, 200, 300);
    applyStimulus(-400, 500, -600);
    applyStimulus(700, -800, 900);
    idle(4);
    #3;
    checkOutput("stallInReady", bus.inReady, 0);
    checkOutput("stallOutValid", bus.outValid, 1);
    @(negedge clk);
    bus.outReady = 1'b1;
    idle(1);
    waitDrain();

    $display("[TB] reset mid-stream");
    @(negedge clk);
    bus.outReady = 1'b0;
    applyStimulus(1000, 2000, 3000);
    applyStimulus(-1000, -2000, -3000);
    applyStimulus(1234, -4321, 55);
    idle(2);
    #4;
    rst_n = 1'b0;
    scoreboard.delete();
    #1;
    checkOutput("midResetOutValid", bus.outValid, 0);
    checkOutput("midResetA", bus.a, 0);
    checkOutput("midResetB", bus.b, 0);
    checkOutput("midResetC", bus.c, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.outReady = 1'b1;
    idle(8);
    #3;
    checkOutput("noGhostOutput", bus.outValid, 0);

    $display("[TB] randomized traffic");
    randReady = 1'b1;
    repeat (300) begin
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
      ra = W'($urandom());
      rb = W'($urandom());
      rg = ($urandom_range(0, 1) == 0) ? W'($urandom()) : W'($urandom_range(0, 2000) - 1000);
      applyStimulus(ra, rb, rg);
    end
    idle(1);
    randReady = 1'b0;
    @(negedge clk);
    bus.outReady = 1'b1;
    waitDrain();

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
